hazard_ctrl: RTL

Pipeline hazard controller for the five-stage RV32I core. Detects load-use dependencies, taken-branch redirects and multi-cycle data-memory accesses, and drives the per-stage stall, flush and freeze controls that sequence the decode→execute operand-forwarding datapath. Sits beside the pipeline registers in `pd`. Consumes decode/execute/memory stage fields and produces enables the stage registers honour the same cycle.

---
 rtl/pd_pkg.sv | 18 +
 rtl/hazard_wait_timer.sv | 31 +++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pd_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encodings and the x0 index.
package pd_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hazard_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A source register depends on rd only when it is actually read and rd is not x0.
  function automatic logic src_depends(input logic used, input logic [4:0] rs,
                                       input logic [4:0] rd);
    return used && (rd != REG_X0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_wait_timer.sv
// Clearable up-counter tracking how many freeze cycles a data-memory access has taken.
// tc flags the final legal freeze cycle (count == TIMEOUT_CYCLES-1).
module hazard_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Wait counter: clear has priority over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; entering a wait freezes the pipe this cycle
// MEM_WAIT | data access outstanding; pipe frozen until dmem_ack
// ERROR    | access timed out; pipe frozen until reset
module hazard_ctrl
  import pd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       rs1_decode,
  input  logic [4:0]       rs2_decode,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [4:0]       rd_execute,
  input  logic             execute_is_load,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             flush_decode,
  output logic             flush_execute,
  output logic             freeze,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             mem_timeout
);

  hazard_state_e state, state_nxt;
  logic          freeze_c;
  logic          timer_clr;
  logic          timer_inc;
  logic          timer_tc;
  logic          set_timeout;
  logic          load_use;
  logic          ctl_en;

  assign load_use = execute_is_load &&
                    (src_depends(rs1_used, rs1_decode, rd_execute) ||
                     src_depends(rs2_used, rs2_decode, rd_execute));

  hazard_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .tc     (timer_tc)
  );

  // State register and sticky timeout flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (set_timeout) mem_timeout <= 1'b1;
    end
  end

  // Next state, freeze and wait-timer control. The timer counts every freeze
  // cycle, including the RUN cycle that starts the wait.
  always_comb begin
    state_nxt   = state;
    freeze_c    = 1'b0;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    set_timeout = 1'b0;
    case (state)
      ST_RUN: begin
        if (dmem_req && !dmem_ack) begin
          freeze_c  = 1'b1;
          timer_inc = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else begin
          timer_clr = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          timer_clr = 1'b1;
          state_nxt = ST_RUN;
        end else if (timer_tc) begin
          freeze_c    = 1'b1;
          timer_clr   = 1'b1;
          set_timeout = 1'b1;
          state_nxt   = ST_ERROR;
        end else begin
          freeze_c  = 1'b1;
          timer_inc = 1'b1;
        end
      end
      ST_ERROR: begin
        freeze_c  = 1'b1;
        timer_clr = 1'b1;
      end
      default: begin
        timer_clr = 1'b1;
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Freeze overrides stall/flush; a taken branch kills the dependent instruction,
  // so it suppresses the load-use stall. Everything is held low during reset.
  assign ctl_en        = reset_n && !freeze_c;
  assign stall_fetch   = ctl_en && load_use && !branch_taken;
  assign stall_decode  = stall_fetch;
  assign flush_decode  = ctl_en && branch_taken;
  assign flush_execute = ctl_en && (branch_taken || load_use);
  assign freeze        = reset_n && freeze_c;

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_stall_cnt <= '0;
      mem_wait_cnt   <= '0;
      flush_cnt      <= '0;
    end else begin
      if (stall_fetch)  load_stall_cnt <= load_stall_cnt + 1'b1;
      if (freeze)       mem_wait_cnt   <= mem_wait_cnt + 1'b1;
      if (flush_decode) flush_cnt      <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
